// File: rtl/mdio_pkg.sv
// mdio_pkg: shared opcodes, frame field positions, bit counts and FSM state type for the MDIO master.
// MDIO_MASTER_PREAMBLE_EN adds the PREAMBLE state to the enum.
package mdio_pkg;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int PHYAD_LSB = 23;
  localparam int REGAD_MSB = 22;
  localparam int REGAD_LSB = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;
  localparam int PRE_BITS  = 32;
  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
`ifdef MDIO_MASTER_PREAMBLE_EN
    ST_PRE   = 3'd1,
`endif
    ST_SHIFT = 3'd2,
    ST_TA    = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } mdio_state_t;
  function automatic logic [4:0] last_idx(input int n);
    return 5'(n - 1);
  endfunction
endpackage

// File: rtl/mdio_clock_gen.sv
// mdio_clock_gen: CLK_DIV divider producing mdc and single-cycle strobes for the cycle in which mdc rises or falls.
module mdio_clock_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic riseStrobe,
  output logic fallStrobe
);
  logic [7:0] cnt;
  logic wrap;
  assign wrap       = cnt == 8'(CLK_DIV - 1);
  assign riseStrobe = en && wrap && !mdc;
  assign fallStrobe = en && wrap && mdc;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO serial engine; shifts one 32-bit frame out on MDC/MDIO and captures read data.
// MDIO_MASTER_PREAMBLE_EN defined: each frame is preceded by 32 ones; undefined: preamble suppressed.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] frameIn,
  input  logic        frameValid,
  output logic        frameReady,
  output logic [15:0] rdData,
  output logic        rdValid,
  output logic        rdError,
  output logic        busy,
  output logic        mdc,
  output logic        mdioOut,
  output logic        mdioOe,
  input  logic        mdioIn
);
  mdio_state_t state;
  logic [31:0] sr;
  logic [4:0]  bit_cnt;
  logic        is_read;
  logic        ta_err;
  logic [15:0] cap;
  logic        rise;
  logic        fall;
  logic        accept;
  assign accept = frameValid && frameReady;
  mdio_clock_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk        (clk),
    .reset      (reset),
    .en         (busy),
    .mdc        (mdc),
    .riseStrobe (rise),
    .fallStrobe (fall)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      is_read    <= 1'b0;
      ta_err     <= 1'b0;
      cap        <= '0;
      frameReady <= 1'b1;
      busy       <= 1'b0;
      rdData     <= '0;
      rdValid    <= 1'b0;
      rdError    <= 1'b0;
      mdioOut    <= 1'b1;
      mdioOe     <= 1'b0;
    end else begin
      rdValid <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          is_read    <= frameIn[OP_MSB:OP_LSB] == MDIO_OP_READ;
          frameReady <= 1'b0;
          busy       <= 1'b1;
          mdioOe     <= 1'b1;
          bit_cnt    <= '0;
`ifdef MDIO_MASTER_PREAMBLE_EN
          state      <= ST_PRE;
          sr         <= frameIn;
          mdioOut    <= 1'b1;
`else
          state      <= ST_SHIFT;
          sr         <= {frameIn[30:0], 1'b0};
          mdioOut    <= frameIn[31];
`endif
        end
`ifdef MDIO_MASTER_PREAMBLE_EN
        ST_PRE: if (fall) begin
          if (bit_cnt == last_idx(PRE_BITS)) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            mdioOut <= sr[31];
            sr      <= {sr[30:0], 1'b0};
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
`endif
        ST_SHIFT: if (fall) begin
          mdioOut <= sr[31];
          sr      <= {sr[30:0], 1'b0};
          if (bit_cnt == last_idx(HDR_BITS)) begin
            state   <= ST_TA;
            bit_cnt <= '0;
            mdioOe  <= !is_read;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ST_TA: begin
          // a PHY that answers pulls the second turnaround bit low
          if (rise && bit_cnt == 5'd1) ta_err <= mdioIn;
          if (fall) begin
            mdioOut <= sr[31];
            sr      <= {sr[30:0], 1'b0};
            state   <= bit_cnt == last_idx(TA_BITS) ? ST_DATA : ST_TA;
            bit_cnt <= bit_cnt == last_idx(TA_BITS) ? 5'd0 : bit_cnt + 5'd1;
          end
        end
        ST_DATA: begin
          if (rise) cap <= {cap[14:0], mdioIn};
          if (fall) begin
            if (bit_cnt == last_idx(DATA_BITS)) begin
              state   <= ST_DONE;
              bit_cnt <= '0;
              mdioOe  <= 1'b0;
              mdioOut <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              mdioOut <= sr[31];
              sr      <= {sr[30:0], 1'b0};
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          frameReady <= 1'b1;
          busy       <= 1'b0;
          if (is_read) begin
            rdData  <= cap;
            rdError <= ta_err;
            rdValid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: randomized self-checking bench for mdio_master with a bit-level PHY and frame reference model.
module tb_mdio_master;
  localparam int C = 2;
`ifdef MDIO_MASTER_PREAMBLE_EN
  localparam int NB = 64;
`else
  localparam int NB = 32;
`endif
  localparam int FLEN = NB * 2 * C + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] frame_in = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_error;
  logic        busy;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] m_rd_data = '0;
  logic        m_rd_err = 1'b0;

  mdio_master #(.CLK_DIV(C)) dut (
    .clk        (clk),
    .reset      (rst),
    .frameIn    (frame_in),
    .frameValid (frame_valid),
    .frameReady (frame_ready),
    .rdData     (rd_data),
    .rdValid    (rd_valid),
    .rdError    (rd_error),
    .busy       (busy),
    .mdc        (mdc),
    .mdioOut    (mdio_out),
    .mdioOe     (mdio_oe),
    .mdioIn     (mdio_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one frame from offer to idle; a PHY answers reads from pd/ta2 and every
  // mdc rise records what the master drives, compared afterwards against the frame.
  task automatic run_frame(input logic [31:0] f, input logic [15:0] pd, input logic ta2,
                           input logic hold, input logic [31:0] nxt);
    logic rd;
    logic [63:0] exp_out, exp_oe, mask, obs_out, obs_oe, resp;
    int nbit, rv_cyc, rdy_cyc, w;
    logic pm;
    rd = f[29:28] == 2'b10;
    exp_out = '0; exp_oe = '0; mask = '0; resp = '1;
    for (int i = 0; i < NB; i++) begin
      int j;
      j = i - (NB - 32);
      mask[i] = 1'b1;
      exp_oe[i] = 1'b1;
      exp_out[i] = 1'b1;
      if (j >= 0) exp_out[i] = f[31 - j];
      if (rd && j >= 14) begin
        exp_oe[i] = 1'b0;
        mask[i] = 1'b0;
      end
    end
    if (rd) begin
      resp[NB - 17] = ta2;
      for (int d = 0; d < 16; d++) resp[NB - 16 + d] = pd[15 - d];
    end
    mdio_in = resp[0];
    w = 0;
    while (!frame_ready && w < FLEN + 20) begin
      @(negedge clk);
      w++;
    end
    if (!frame_ready) check("ready_timeout", 64'(frame_ready), 64'd1);
    frame_in = f;
    frame_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) frame_in = nxt;
    else frame_valid = 1'b0;
    check("busy_after_accept", 64'({frame_ready, busy}), 64'b01);
    nbit = 0; pm = 1'b0; rv_cyc = 0; rdy_cyc = 0; obs_out = '0; obs_oe = '0;
    for (int k = 0; k < FLEN + 8; k++) begin
      if (k > 0) @(negedge clk);
      if (mdc && !pm) begin
        if (nbit < 64) begin
          obs_out[nbit] = mdio_out;
          obs_oe[nbit] = mdio_oe;
        end
        nbit++;
      end
      if (!mdc && pm) mdio_in = resp[nbit < 64 ? nbit : 63];
      pm = mdc;
      if (rd_valid && rv_cyc == 0) rv_cyc = k;
      if (k > 0 && frame_ready) begin
        rdy_cyc = k;
        break;
      end
    end
    if (rd) begin
      m_rd_data = pd;
      m_rd_err = ta2;
    end
    check("mdc_bits", 64'(nbit), 64'(NB));
    check("mdio_out_bits", obs_out & mask, exp_out & mask);
    check("mdio_oe_bits", obs_oe, exp_oe);
    check("ready_cycle", 64'(rdy_cyc), 64'(FLEN));
    check("rdvalid_cycle", 64'(rv_cyc), rd ? 64'(FLEN) : 64'd0);
    check("rd_data", 64'(rd_data), 64'(m_rd_data));
    check("rd_error", 64'(rd_error), 64'(m_rd_err));
    check("idle_lines", 64'({busy, mdc, mdio_oe, mdio_out}), 64'b0001);
    if (!hold) begin
      @(negedge clk);
      check("rdvalid_pulse", 64'(rd_valid), 64'd0);
    end
  endtask

  initial begin
    logic mdc_seen;
    logic rv_seen;
    logic [31:0] f;
    // reset with a frame offered
    rst = 1'b1;
    frame_valid = 1'b1;
    frame_in = 32'h6087_0000;
    mdc_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      mdc_seen |= mdc;
    end
    check("reset_outputs", 64'({frame_ready, busy, rd_valid, rd_error, rd_data, mdc, mdio_out, mdio_oe}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}));
    check("reset_no_mdc", 64'(mdc_seen), 64'd0);
    frame_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 64'({frame_ready, busy}), 64'b10);

    run_frame(32'h5082_1140, 16'h0000, 1'b0, 1'b0, 32'h0);
    run_frame(32'h6087_0000, 16'h7809, 1'b0, 1'b0, 32'h0);
    run_frame(32'h6087_0000, 16'hFFFF, 1'b1, 1'b0, 32'h0);
    // back-to-back: second frame waits while the first is in flight
    run_frame(32'h6087_0000, 16'h7809, 1'b0, 1'b1, 32'h5082_1140);
    run_frame(32'h5082_1140, 16'h0000, 1'b0, 1'b0, 32'h0);

    // random frames over all opcodes
    for (int r = 0; r < 10; r++) begin
      f = {2'b01, 2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 2'b10, 16'($urandom)};
      run_frame(f, 16'($urandom), $urandom_range(0, 3) == 0, 1'b0, 32'h0);
    end

    // reset 100 cycles into a read
    frame_in = 32'h6087_0000;
    frame_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    rv_seen = 1'b0;
    repeat (99) begin
      @(negedge clk);
      rv_seen |= rd_valid;
    end
    check("midreset_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midreset_outputs", 64'({mdio_oe, mdc, frame_ready, busy, rd_valid, rd_data}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}));
    @(negedge clk);
    rst = 1'b0;
    m_rd_data = '0;
    m_rd_err = 1'b0;
    repeat (FLEN) begin
      @(negedge clk);
      rv_seen |= rd_valid;
      mdc_seen |= mdc;
    end
    check("midreset_no_rdvalid", 64'(rv_seen), 64'd0);
    check("midreset_no_mdc", 64'(mdc_seen), 64'd0);
    check("midreset_rd_data", 64'({rd_data, rd_error}), 64'({m_rd_data, m_rd_err}));
    run_frame(32'h6087_0000, 16'h7809, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
